// File: rtl/matrix_stream_host_pkg.sv
// Shared definitions for the floating-point matrix host: element width,
// controller state encoding and the flattened-bus slot addressing helpers.
package matrix_stream_host_pkg;

    localparam int ELEMENT_LENGTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_A      = 3'd1,
        ST_LOAD_B      = 3'd2,
        ST_START       = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_ACK         = 3'd5,
        ST_SEND        = 3'd6
    } state_t;

    // Slot 0 sits in the most significant element of a flattened bus.
    function automatic int slot_msb(input int width, input int slot);
        return width - 1 - ELEMENT_LENGTH * slot;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matrix_stream_host_word_packer.sv
// Slot-addressed element register presented as one flattened bus,
// slot 0 in the MSBs. One element is written per enabled cycle.
module word_packer
    import matrix_stream_host_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int ADDR_W = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [ADDR_W-1:0]                 wr_slot,
    input  logic [ELEMENT_LENGTH-1:0]         wr_data,
    output logic [SLOTS*ELEMENT_LENGTH-1:0]   bus
);

    localparam int BUS_W = SLOTS * ELEMENT_LENGTH;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [ELEMENT_LENGTH-1:0] slot_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_reg <= '0;
            end else if (wr_en && (wr_slot == ADDR_W'(gi))) begin
                slot_reg <= wr_data;
            end
        end

        assign bus[slot_msb(BUS_W, gi) -: ELEMENT_LENGTH] = slot_reg;
    end

endmodule

// File: rtl/matrix_stream_host.sv
// Serial-to-parallel host for the matrix multiplier: packs A and B from an
// element stream, starts the multiplier, captures its result and streams it out.
module matrix_stream_host
    import matrix_stream_host_pkg::*;
#(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [ELEMENT_LENGTH-1:0]                             in_data,
    input  logic                                                  in_stb,
    output logic                                                  in_ack,
    output logic [ELEMENT_LENGTH*NUM_FIRST_ROW*NUM_FIRST_COL-1:0] mm_In1,
    output logic [ELEMENT_LENGTH*NUM_FIRST_COL*NUM_SECOND_COL-1:0] mm_In2,
    output logic                                                  mm_load,
    input  logic [ELEMENT_LENGTH*NUM_FIRST_ROW*NUM_SECOND_COL-1:0] mm_Out,
    input  logic                                                  mm_out_ready,
    output logic                                                  mm_out_ack,
    output logic [ELEMENT_LENGTH-1:0]                             out_data,
    output logic                                                  out_stb,
    input  logic                                                  out_ack,
    output logic                                                  busy
);

    localparam int NUM_A   = NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int NUM_B   = NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int NUM_OUT = NUM_FIRST_ROW * NUM_SECOND_COL;
    localparam int NUM_MAX = max3(NUM_A, NUM_B, NUM_OUT);
    localparam int CNT_W   = $clog2(NUM_MAX + 1);
    localparam int OUT_W   = NUM_OUT * ELEMENT_LENGTH;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          count_reg, count_next;
    logic                      in_ack_reg, in_ack_next;
    logic                      mm_load_reg, mm_load_next;
    logic                      mm_out_ack_reg, mm_out_ack_next;
    logic                      out_stb_reg, out_stb_next;
    logic                      busy_reg, busy_next;
    logic [ELEMENT_LENGTH-1:0] out_data_reg, out_data_next;
    logic [ELEMENT_LENGTH-1:0] result_reg [NUM_OUT];
    logic [ELEMENT_LENGTH-1:0] out_slot [NUM_OUT];
    logic                      capture;
    logic                      wr_a;
    logic                      wr_b;
    logic                      in_fire;
    logic                      out_fire;

    assign in_fire  = in_stb && in_ack_reg;
    assign out_fire = out_stb_reg && out_ack;

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        capture         = 1'b0;
        wr_a            = 1'b0;
        wr_b            = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_LOAD_A;
                count_next = '0;
            end
            ST_LOAD_A: begin
                if (in_fire) begin
                    wr_a = 1'b1;
                    if (count_reg == CNT_W'(NUM_A - 1)) begin
                        count_next = '0;
                        state_next = ST_LOAD_B;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_fire) begin
                    wr_b = 1'b1;
                    if (count_reg == CNT_W'(NUM_B - 1)) begin
                        count_next = '0;
                        state_next = ST_START;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_next = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                if (mm_out_ready) begin
                    capture    = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_SEND;
                count_next = '0;
            end
            ST_SEND: begin
                if (out_fire) begin
                    if (count_reg == CNT_W'(NUM_OUT - 1)) begin
                        count_next = '0;
                        state_next = ST_IDLE;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase

        // Outputs are registered versions of what the next state demands.
        in_ack_next     = (state_next == ST_LOAD_A) || (state_next == ST_LOAD_B);
        mm_load_next    = (state_next == ST_START);
        mm_out_ack_next = (state_next == ST_ACK);
        out_stb_next    = (state_next == ST_SEND);
        busy_next       = (state_next != ST_IDLE);
    end

    always_comb begin
        out_data_next = out_data_reg;
        if (state_next == ST_SEND) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (count_next == CNT_W'(i)) begin
                    out_data_next = result_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            in_ack_reg     <= 1'b0;
            mm_load_reg    <= 1'b0;
            mm_out_ack_reg <= 1'b0;
            out_stb_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            in_ack_reg     <= in_ack_next;
            mm_load_reg    <= mm_load_next;
            mm_out_ack_reg <= mm_out_ack_next;
            out_stb_reg    <= out_stb_next;
            busy_reg       <= busy_next;
            out_data_reg   <= out_data_next;
        end
    end

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out_slot
        assign out_slot[gi] = mm_Out[slot_msb(OUT_W, gi) -: ELEMENT_LENGTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                result_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                result_reg[i] <= out_slot[i];
            end
        end
    end

    word_packer #(
        .SLOTS  (NUM_A),
        .ADDR_W (CNT_W)
    ) u_pack_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_a),
        .wr_slot (count_reg),
        .wr_data (in_data),
        .bus     (mm_In1)
    );

    word_packer #(
        .SLOTS  (NUM_B),
        .ADDR_W (CNT_W)
    ) u_pack_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_b),
        .wr_slot (count_reg),
        .wr_data (in_data),
        .bus     (mm_In2)
    );

    assign in_ack     = in_ack_reg;
    assign mm_load    = mm_load_reg;
    assign mm_out_ack = mm_out_ack_reg;
    assign out_stb    = out_stb_reg;
    assign busy       = busy_reg;
    assign out_data   = out_data_reg;

endmodule
